sha256_msg_sched: RTL and testbench
===================================

# sha256_msg_sched

Custom functional unit that performs the full SHA-256 message-schedule expansion step W[t] = sig1(W[t-2]) + W[t-7] + sig0(W[t-15]) + W[t-16]. It holds a 16-word sliding window internally, so software loads the 16 message words once and then issues one instruction per expanded word. It sits in the CFU slot as the consumer of the sigma-1 and sigma-0 primitives and replaces the per-round sig0/sig1/add instruction sequence.

## Interface
Parameters:
- NUM_EXPAND, default 48: number of NEXT operations permitted per block when the limit check is compiled in.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset. rst = 0 clears all state immediately.
- cfu  slave  cfu_interface  request/response channel. Uses req_valid, req_ready, req_id, req_function_id, rs1, rs2, resp_valid, resp_ready, resp_id, resp_status, resp_data.

## Operation
- Window: 16 x 32-bit circular buffer buf[0..15] with a 4-bit head pointer. head indexes W[t-16]. Offsets: W[t-15] = buf[head+1], W[t-7] = buf[head+9], W[t-2] = buf[head+14]. All offsets are mod 16.
- sig0(x) = ror(x,7) ^ ror(x,18) ^ (x>>3). sig1(x) = ror(x,17) ^ ror(x,19) ^ (x>>10). All additions are mod 2^32.
- req_function_id[1:0]:
  - 0 INIT: head <= 0, count <= 0. resp_data = 0, status 0.
  - 1 LOAD: buf[rs2[3:0]] <= rs1. The index is absolute and ignores head. resp_data = rs1, status 0.
  - 2 NEXT: computes W[t], writes it to buf[head], then head <= head+1 and count <= count+1. resp_data = W[t], status 0.
  - 3 reserved: no state change. resp_data = 0, status 1.
- FSM: IDLE -> (accept LOAD/INIT/reserved) -> RESP; IDLE -> (accept NEXT) -> CALC -> RESP; RESP -> (resp_ready) -> IDLE.
- CALC registers two partial sums: p0 = sig1(W[t-2]) + W[t-7] and p1 = sig0(W[t-15]) + W[t-16]. In RESP, resp_data = p0 + p1, and the buffer and head update once on entry to RESP.
- resp_id echoes the req_id captured at acceptance.
- The block does not track whether the window has been fully loaded. NEXT after a partial LOAD uses whatever the buffer contains.

## Timing
- Reset values: req_ready = 1, resp_valid = 0, resp_id = 0, resp_status = 0, resp_data = 0, head = 0, count = 0, buf = all zeros, FSM = IDLE.
- req_ready is high only in IDLE. A request is accepted on a cycle where req_valid and req_ready are both high.
- Latency from acceptance in cycle N:
  - LOAD, INIT, reserved: resp_valid rises in N+1.
  - NEXT: resp_valid rises in N+2.
- resp_valid, resp_data, resp_id and resp_status stay stable until the cycle where resp_ready is high. That cycle is the response handshake.
- resp_ready in the same cycle as the first resp_valid completes the handshake. In that case resp_valid = 0 and req_ready = 1 in the next cycle.
- A request is never accepted in the same cycle as a response handshake. Minimum spacing between back-to-back NEXT acceptances is therefore 3 cycles.
- resp_ready while resp_valid is low is ignored.
- head wraps 15 -> 0 without any special case.
- Reset asserted mid-operation aborts it. Any pending response is discarded and the buffer is cleared.

## Configuration
- SHA256_SCHED_LIMIT_EN defined:
  - count saturates at NUM_EXPAND.
  - A NEXT issued when count == NUM_EXPAND returns status 1 and data 0, leaves buf, head and count unchanged, and keeps the same NEXT latency.
- SHA256_SCHED_LIMIT_EN undefined:
  - No count register; count reads as a constant.
  - NEXT always executes and always returns status 0.

## Test plan
- Reset: hold rst = 0 for 3 cycles, then release. Expect req_ready = 1, resp_valid = 0, resp_data = 0. Expect NEXT immediately after release to return 0x00000000.
- "abc" block:
  - Stimulus: INIT, then LOAD W0 = 0x61626380, W1..W14 = 0, W15 = 0x00000018, then three NEXTs.
  - Expected data: 0x61626380, 0x000F0000, 0x7DA86405, each with status 0.
  - Expected timing: resp_valid exactly 2 cycles after each NEXT acceptance.
- Backpressure: hold resp_ready = 0 for 5 cycles after a NEXT. Expect resp_valid and resp_data stable throughout, req_ready = 0 throughout, and a second req_valid not accepted until 1 cycle after the handshake.
- Wrap and limit with SHA256_SCHED_LIMIT_EN defined:
  - Issue 48 NEXTs. Expect head = 0 after every 16th NEXT, and results matching a golden model.
  - Issue a 49th NEXT. Expect status 1, data 0, and a following reserved-free LOAD/NEXT sequence unaffected by the rejected NEXT.
  - Without the macro, the 49th NEXT returns the model value with status 0.
- Reserved and ID: function 3 with req_id = 5 -> resp_status = 1, resp_data = 0, resp_id = 5, and buffer unchanged, checked by a subsequent NEXT matching the model.
- Mid-operation reset: assert rst = 0 in the CALC cycle of a NEXT. Expect resp_valid = 0 immediately (asynchronous), req_ready = 1 after release, and buffer zeros confirmed by a NEXT returning 0.

Source files
------------

// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched: SHA-256 message-schedule expansion unit with a 16-word sliding window; define SHA256_SCHED_LIMIT_EN to cap NEXTs per block at NUM_EXPAND
module sha256_msg_sched #(
   parameter int NUM_EXPAND = 48
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [7:0]  req_id,
   input  logic [9:0]  req_function_id,
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [7:0]  resp_id,
   output logic        resp_status,
   output logic [31:0] resp_data
);
   localparam int CW = $clog2(NUM_EXPAND + 1);
   typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
   state_t state, state_nx;
   logic [31:0] win [16];
   logic [3:0]  head;
   logic [31:0] p0, p1, s0, s1;
   logic [1:0]  fn;
   logic        accept, limit_hit;
   logic        unused;
   function automatic logic [31:0] sig0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction
   function automatic logic [31:0] sig1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction
   assign fn         = req_function_id[1:0];
   assign req_ready  = state == IDLE;
   assign resp_valid = state == RESP;
   assign accept     = req_valid && req_ready;
   assign resp_data  = p0 + p1;
   assign unused     = ^{rs2[31:4], req_function_id[9:2]} ^ (CW == 0);
   assign s0 = sig1(win[head + 4'd14]) + win[head + 4'd9];
   assign s1 = sig0(win[head + 4'd1]) + win[head];
`ifdef SHA256_SCHED_LIMIT_EN
   logic [CW-1:0] count;
   assign limit_hit = count == CW'(NUM_EXPAND);
   // count of executed NEXTs since INIT; stops advancing once the limit is hit
   always_ff @(posedge clk or negedge rst)
      if (!rst) count <= '0;
      else if (accept && fn == 2'd0) count <= '0;
      else if (state == CALC && !limit_hit) count <= count + CW'(1);
`else
   assign limit_hit = 1'b0;
`endif
   // state register
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else state <= state_nx;
   // next state: NEXT takes an extra CALC cycle, everything else answers directly
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = !req_valid ? IDLE : (fn == 2'd2 ? CALC : RESP);
         CALC:    state_nx = RESP;
         RESP:    state_nx = resp_ready ? IDLE : RESP;
         default: state_nx = IDLE;
      endcase
   end
   // window, head and response registers; resp_data is always p0 + p1
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         head        <= '0;
         p0          <= '0;
         p1          <= '0;
         resp_id     <= '0;
         resp_status <= 1'b0;
         for (int i = 0; i < 16; i++) win[i] <= '0;
      end else if (accept) begin
         resp_id     <= req_id;
         resp_status <= fn == 2'd3;
         p0          <= fn == 2'd1 ? rs1 : '0;
         p1          <= '0;
         if (fn == 2'd0) head <= '0;
         if (fn == 2'd1) win[rs2[3:0]] <= rs1;
      end else if (state == CALC) begin
         resp_status <= limit_hit;
         p0          <= limit_hit ? '0 : s0;
         p1          <= limit_hit ? '0 : s1;
         if (!limit_hit) begin
            win[head] <= s0 + s1;
            head      <= head + 4'd1;
         end
      end
endmodule

// File: tb/tb_sha256_msg_sched.sv
// tb_sha256_msg_sched: table vectors, randomized ops against a reference model, and hand-written handshake/reset sequences
module tb_sha256_msg_sched;
   logic        clk = 0, rst = 1;
   logic        req_valid = 0, req_ready, resp_valid, resp_ready = 0, resp_status;
   logic [7:0]  req_id = 0, resp_id;
   logic [9:0]  req_function_id = 0;
   logic [31:0] rs1 = 0, rs2 = 0, resp_data;
   int checks = 0, errors = 0;
   logic [31:0] m [16];
   int mh = 0, mcnt = 0;
   typedef struct {logic [1:0] fn; logic [31:0] a; logic [31:0] b; logic [31:0] exp; logic st;} vec_t;
   vec_t tab[$];

   sha256_msg_sched dut (.clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id),
      .req_function_id(req_function_id), .rs1(rs1), .rs2(rs2), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_id(resp_id), .resp_status(resp_status), .resp_data(resp_data));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction
   function automatic logic [31:0] sg0(input logic [31:0] x);
      return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
   endfunction
   function automatic logic [31:0] sg1(input logic [31:0] x);
      return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
   endfunction
   // W[t-16+k] in the model window
   function automatic logic [31:0] wk(input int k);
      return m[(mh + k) % 16];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m[i] = 0;
      mh = 0;
      mcnt = 0;
   endtask

   task automatic mdl(input logic [1:0] fn, input logic [31:0] a, input logic [31:0] b, output logic [31:0] d, output logic st);
      d = 0;
      st = 0;
      case (fn)
         2'd0: begin mh = 0; mcnt = 0; end
         2'd1: begin m[b[3:0]] = a; d = a; end
         2'd2: begin
`ifdef SHA256_SCHED_LIMIT_EN
            if (mcnt == 48) begin st = 1; return; end
`endif
            d = sg1(wk(14)) + wk(9) + sg0(wk(1)) + wk(0);
            m[mh] = d;
            mh = (mh + 1) % 16;
            mcnt++;
         end
         default: st = 1;
      endcase
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic op(input logic [1:0] fn, input logic [31:0] a, input logic [31:0] b, input logic [7:0] id,
                     output logic [31:0] d, output logic st, output logic [7:0] rid, output int lat);
      int w = 0;
      @(negedge clk);
      while (!req_ready && w < 20) begin @(negedge clk); w++; end
      if (!req_ready) chk("req_ready_wait", 32'(req_ready), 32'd1);
      req_valid = 1;
      req_function_id = {8'd0, fn};
      rs1 = a;
      rs2 = b;
      req_id = id;
      resp_ready = 1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 0;
      lat = 1;
      while (!resp_valid && lat < 20) begin @(negedge clk); lat++; end
      d = resp_data;
      st = resp_status;
      rid = resp_id;
   endtask

   task automatic check_op(input string nm, input logic [1:0] fn, input logic [31:0] a, input logic [31:0] b,
                           input logic [7:0] id, input logic [31:0] ed, input logic es);
      logic [31:0] d;
      logic st;
      logic [7:0] rid;
      int lat;
      op(fn, a, b, id, d, st, rid, lat);
      chk({nm, "_data"}, d, ed);
      chk({nm, "_status"}, 32'(st), 32'(es));
      chk({nm, "_id"}, 32'(rid), 32'(id));
      chk({nm, "_latency"}, lat, fn == 2'd2 ? 32'd2 : 32'd1);
   endtask

   task automatic step(input string nm, input logic [1:0] fn, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] ed;
      logic es;
      mdl(fn, a, b, ed, es);
      check_op(nm, fn, a, b, 8'($urandom), ed, es);
   endtask

   initial begin
      logic [31:0] ed;
      logic es;
      tab.push_back('{2'd0, 32'h0, 32'h0, 32'h0, 1'b0});
      for (int i = 0; i < 16; i++) begin
         logic [31:0] v;
         v = i == 0 ? 32'h61626380 : (i == 15 ? 32'h00000018 : 32'h0);
         tab.push_back('{2'd1, v, 32'(i), v, 1'b0});
      end
      tab.push_back('{2'd2, 32'h0, 32'h0, 32'h61626380, 1'b0});
      tab.push_back('{2'd2, 32'h0, 32'h0, 32'h000F0000, 1'b0});
      tab.push_back('{2'd2, 32'h0, 32'h0, 32'h7DA86405, 1'b0});
      #1 rst = 0;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_data", resp_data, 32'd0);
      chk("rst_resp_status", 32'(resp_status), 32'd0);
      chk("rst_resp_id", 32'(resp_id), 32'd0);
      rst = 1;
      model_reset();
      mdl(2'd2, 0, 0, ed, es);
      check_op("next_after_rst", 2'd2, 0, 0, 8'h11, 32'h0, 1'b0);
      foreach (tab[i]) begin
         mdl(tab[i].fn, tab[i].a, tab[i].b, ed, es);
         check_op($sformatf("abc%0d", i), tab[i].fn, tab[i].a, tab[i].b, 8'(i), tab[i].exp, tab[i].st);
      end
      // backpressure: NEXT held in RESP for 5 cycles while a LOAD waits
      mdl(2'd2, 0, 0, ed, es);
      @(negedge clk);
      req_valid = 1; req_function_id = 10'd2; req_id = 8'd7; resp_ready = 0;
      @(posedge clk);
      @(negedge clk);
      req_function_id = 10'd1; rs1 = 32'hCAFEF00D; rs2 = 32'd3; req_id = 8'd8;
      chk("bp_ready_calc", 32'(req_ready), 32'd0);
      chk("bp_valid_calc", 32'(resp_valid), 32'd0);
      @(negedge clk);
      chk("bp_valid_first", 32'(resp_valid), 32'd1);
      chk("bp_data_first", resp_data, ed);
      chk("bp_id_first", 32'(resp_id), 32'd7);
      repeat (5) begin
         @(negedge clk);
         chk("bp_valid_hold", 32'(resp_valid), 32'd1);
         chk("bp_data_hold", resp_data, ed);
         chk("bp_ready_hold", 32'(req_ready), 32'd0);
      end
      resp_ready = 1;
      @(negedge clk);
      chk("bp_valid_after_hs", 32'(resp_valid), 32'd0);
      chk("bp_ready_after_hs", 32'(req_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 0;
      mdl(2'd1, 32'hCAFEF00D, 32'd3, ed, es);
      chk("bp_load_valid", 32'(resp_valid), 32'd1);
      chk("bp_load_data", resp_data, 32'hCAFEF00D);
      chk("bp_load_id", 32'(resp_id), 32'd8);
      // reserved function with id echo, buffer untouched
      mdl(2'd3, 32'hFFFF, 32'h1, ed, es);
      check_op("rsv", 2'd3, 32'hFFFF, 32'h1, 8'd5, 32'h0, 1'b1);
      step("rsv_next", 2'd2, 0, 0);
      // randomized ops against the model
      step("rnd_init", 2'd0, 0, 0);
      for (int i = 0; i < 16; i++) step("rnd_load", 2'd1, $urandom, 32'(i));
      for (int i = 0; i < 150; i++) begin
         int r;
         r = $urandom_range(0, 99);
         step("rnd", r < 50 ? 2'd2 : (r < 85 ? 2'd1 : (r < 95 ? 2'd3 : 2'd0)), $urandom, $urandom);
      end
      // wrap and limit
      step("wl_init", 2'd0, 0, 0);
      for (int i = 0; i < 16; i++) step("wl_load", 2'd1, $urandom, 32'(i));
      for (int i = 0; i < 48; i++) begin
         step("wl_next", 2'd2, 0, 0);
         if ((i + 1) % 16 == 0) chk("wl_head_wrap", 32'(dut.head), 32'd0);
      end
      step("wl_next49", 2'd2, 0, 0);
      step("wl_load_after", 2'd1, 32'h12345678, 32'd5);
      step("wl_next_after", 2'd2, 0, 0);
      // mid-operation reset during CALC
      for (int i = 0; i < 16; i++) step("mr_load", 2'd1, $urandom | 32'h1, 32'(i));
      @(negedge clk);
      req_valid = 1; req_function_id = 10'd2; resp_ready = 1;
      @(posedge clk);
      #1 rst = 0;
      #1;
      chk("mr_valid_async", 32'(resp_valid), 32'd0);
      chk("mr_ready_async", 32'(req_ready), 32'd1);
      req_valid = 0;
      repeat (2) @(negedge clk);
      rst = 1;
      chk("mr_ready_release", 32'(req_ready), 32'd1);
      model_reset();
      mdl(2'd2, 0, 0, ed, es);
      check_op("mr_next", 2'd2, 0, 0, 8'h3C, 32'h0, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
